thread_lsu: RTL and testbench
=============================

THREAD_LSU -- requirements
Module: thread_lsu

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the data width of lsu_out, mem_read_data and mem_write_data.
REQ-002 Parameter ADDR_BITS, default 8, SHALL set the width of mem_read_address and mem_write_address.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 enable  input  1  SHALL be high when this thread is active in the current block; low SHALL freeze all state and outputs.
REQ-006 core_state  input  4  SHALL carry the core pipeline state (REQUEST=4'b0100, UPDATE=4'b0111).
REQ-007 decoded_mem_read_enable  input  1  SHALL be high for LDR.
REQ-008 decoded_mem_write_enable  input  1  SHALL be high for STR.
REQ-009 rs  input  8  SHALL be the address operand.
REQ-010 rt  input  8  SHALL be the store-data operand.
REQ-011 mem_read_valid  output  1 / mem_read_address  output  ADDR_BITS  SHALL form the read request.
REQ-012 mem_read_ready  input  1 / mem_read_data  input  DATA_BITS  SHALL form the read response.
REQ-013 mem_write_valid  output  1 / mem_write_address  output  ADDR_BITS / mem_write_data  output  DATA_BITS  SHALL form the write request.
REQ-014 mem_write_ready  input  1  SHALL acknowledge the write.
REQ-015 lsu_state  output  2  SHALL expose the FSM state to the scheduler.
REQ-016 lsu_out  output  DATA_BITS  SHALL hold the last loaded value, consumed by the register file in UPDATE.

Function
REQ-017 FSM states SHALL be IDLE=2'b00, REQUESTING=2'b01, WAITING=2'b10, DONE=2'b11.
REQ-018 IDLE: when core_state==REQUEST and a read or write enable is high, the FSM SHALL go to REQUESTING next edge; otherwise it stays.
REQ-019 If both read and write enables are high, read SHALL take priority and the write SHALL be ignored.
REQ-020 REQUESTING: the FSM SHALL register valid=1, address=rs[ADDR_BITS-1:0] (and write data=rt for STR) and go to WAITING in one cycle.
REQ-021 WAITING: valid, address and data SHALL be held stable until ready is sampled high.
REQ-022 On ready high in WAITING: LDR SHALL capture mem_read_data into lsu_out; valid SHALL deassert; the FSM SHALL go to DONE, all on the same edge.
REQ-023 Ready sampled while the FSM is outside WAITING SHALL be ignored.
REQ-024 DONE: the FSM SHALL hold until core_state==UPDATE, then go to IDLE next edge; lsu_out SHALL remain unchanged.
REQ-025 Minimum latency: REQUEST cycle to DONE SHALL be 3 edges with ready already high; there SHALL be no timeout.
REQ-026 STR SHALL NOT modify lsu_out.
REQ-027 Only one transaction SHALL be outstanding; a new REQUEST while not IDLE SHALL be ignored.
REQ-028 With enable low mid-transaction, the FSM SHALL freeze; valid SHALL stay asserted if already asserted, and ready SHALL be ignored.

Reset
REQ-029 Reset SHALL set lsu_state=IDLE, lsu_out=0, both valids=0, addresses=0 and mem_write_data=0 on the next edge, including mid-transaction; the abandoned request SHALL NOT be completed.
REQ-030 Reset SHALL take priority over enable.

Structure
REQ-031 The core_state encodings (REQUEST, UPDATE, ISSUE=4'b0011), the lsu_state encodings and the register-input-mux encodings SHALL live in a shared package used by the scheduler, registers and thread_lsu.
REQ-032 The block SHALL be one flat module with no sub-modules; the read and write channels SHALL share one FSM.

Verification
REQ-033 LDR, rs=0x2A, ready=1 on the first WAITING cycle, data=0x5C -> read_valid high one cycle, address 0x2A; lsu_state=DONE; lsu_out=0x5C.
REQ-034 STR, rs=0x10, rt=0xF3, ready delayed 5 cycles -> write_valid, address 0x10 and data 0xF3 held stable for 6 cycles; lsu_out unchanged; DONE.
REQ-035 DONE held for 4 cycles, then core_state=UPDATE -> IDLE next edge; a second LDR then completes normally.
REQ-036 Reset asserted in WAITING of an LDR -> next edge valid=0, lsu_state=IDLE, lsu_out=0; a later ready pulse has no effect.
REQ-037 Both enables high in REQUEST -> only the read channel asserts; mem_write_valid stays 0.
REQ-038 enable dropped 3 cycles in WAITING with ready=1 -> no state change; completes on the first cycle after enable returns.

Source files
------------

// File: rtl/thread_lsu_pkg.sv
// thread_lsu_pkg: shared core/LSU/register-mux encodings
package thread_lsu_pkg;
    localparam logic [3:0] CORE_ISSUE   = 4'b0011;
    localparam logic [3:0] CORE_REQUEST = 4'b0100;
    localparam logic [3:0] CORE_UPDATE  = 4'b0111;
    localparam logic [1:0] LSU_IDLE       = 2'b00;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;
    localparam logic [1:0] LSU_DONE       = 2'b11;
    localparam logic [1:0] REG_IN_ARITH  = 2'b00;
    localparam logic [1:0] REG_IN_MEMORY = 2'b01;
    localparam logic [1:0] REG_IN_CONST  = 2'b10;
endpackage

// File: rtl/thread_lsu.sv
// thread_lsu: per-thread load/store unit, one FSM shared by the read and write channels
module thread_lsu
    import thread_lsu_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs,
    input  logic [7:0]           rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);
    logic [1:0] state;
    logic       is_read;
    assign lsu_state = state;
    // The operation is latched at REQUEST so later decode changes cannot switch channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= LSU_IDLE;
            is_read           <= 1'b0;
            lsu_out           <= '0;
            mem_read_valid    <= 1'b0;
            mem_write_valid   <= 1'b0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else if (enable) begin
            case (state)
                LSU_IDLE:
                    if (core_state == CORE_REQUEST && (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        state   <= LSU_REQUESTING;
                        is_read <= decoded_mem_read_enable;
                    end
                LSU_REQUESTING: begin
                    mem_read_valid  <= is_read;
                    mem_write_valid <= !is_read;
                    if (is_read) mem_read_address <= ADDR_BITS'(rs);
                    else begin
                        mem_write_address <= ADDR_BITS'(rs);
                        mem_write_data    <= DATA_BITS'(rt);
                    end
                    state <= LSU_WAITING;
                end
                LSU_WAITING:
                    if (is_read ? mem_read_ready : mem_write_ready) begin
                        if (is_read) lsu_out <= mem_read_data;
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        state           <= LSU_DONE;
                    end
                default:
                    if (core_state == CORE_UPDATE) state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_thread_lsu.sv
// tb_thread_lsu: directed and randomized transaction checks against a transaction-level model
module tb_thread_lsu;
    import thread_lsu_pkg::*;
    logic       clk = 1'b0, reset = 1'b1, enable = 1'b1;
    logic [3:0] core_state = CORE_ISSUE;
    logic       rd_en = 1'b0, wr_en = 1'b0;
    logic [7:0] rs = '0, rt = '0;
    logic       mem_read_valid, mem_write_valid;
    logic [7:0] mem_read_address, mem_write_address, mem_write_data, lsu_out;
    logic       mem_read_ready = 1'b0, mem_write_ready = 1'b0;
    logic [7:0] mem_read_data = '0;
    logic [1:0] lsu_state;
    int errors = 0, checks = 0;
    logic [7:0] exp_out = '0;

    thread_lsu #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .rt(rt),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outstanding request: only the chosen channel is valid, carrying the request's operands.
    task automatic chk_pending(input bit rd, input logic [7:0] a, input logic [7:0] d, input string tag);
        chk({tag, " state"}, lsu_state, LSU_WAITING);
        chk({tag, " rvalid"}, mem_read_valid, rd);
        chk({tag, " wvalid"}, mem_write_valid, !rd);
        if (rd) chk({tag, " raddr"}, mem_read_address, a);
        else begin
            chk({tag, " waddr"}, mem_write_address, a);
            chk({tag, " wdata"}, mem_write_data, d);
        end
        chk({tag, " out"}, lsu_out, exp_out);
    endtask

    // Drive REQUEST and run the request up to the first WAITING cycle.
    task automatic start(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        core_state = CORE_REQUEST; rd_en = rd; wr_en = wr; rs = a; rt = d;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        tick();
        chk("req state", lsu_state, LSU_REQUESTING);
        chk("req rvalid", mem_read_valid, 1'b0);
        chk("req wvalid", mem_write_valid, 1'b0);
        core_state = CORE_ISSUE; rd_en = 1'b0; wr_en = 1'b0;
        tick();
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rdata, input int delay, input int hold);
        bit op_rd;
        op_rd = rd;
        start(rd, wr, a, d);
        chk_pending(op_rd, a, d, "wait0");
        for (int i = 0; i < delay; i++) begin
            mem_read_ready = !op_rd; mem_write_ready = op_rd;
            mem_read_data = 8'($urandom);
            core_state = ($urandom_range(0, 1) != 0) ? CORE_REQUEST : CORE_ISSUE;
            rd_en = 1'b1;
            tick();
            chk_pending(op_rd, a, d, "waitN");
        end
        core_state = CORE_ISSUE; rd_en = 1'b0;
        mem_read_ready = op_rd; mem_write_ready = !op_rd; mem_read_data = rdata;
        if (op_rd) exp_out = rdata;
        tick();
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        chk("done state", lsu_state, LSU_DONE);
        chk("done rvalid", mem_read_valid, 1'b0);
        chk("done wvalid", mem_write_valid, 1'b0);
        chk("done out", lsu_out, exp_out);
        for (int i = 0; i < hold; i++) begin
            core_state = CORE_REQUEST; rd_en = 1'b1; mem_read_ready = 1'b1;
            mem_read_data = 8'($urandom);
            tick();
            chk("hold state", lsu_state, LSU_DONE);
            chk("hold out", lsu_out, exp_out);
        end
        core_state = CORE_UPDATE; rd_en = 1'b0; mem_read_ready = 1'b0;
        tick();
        chk("update state", lsu_state, LSU_IDLE);
        chk("update out", lsu_out, exp_out);
        core_state = CORE_ISSUE;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst state", lsu_state, LSU_IDLE);
        chk("rst out", lsu_out, 8'h00);
        chk("rst rvalid", mem_read_valid, 1'b0);
        chk("rst wvalid", mem_write_valid, 1'b0);
        chk("rst waddr", mem_write_address, 8'h00);
        chk("rst wdata", mem_write_data, 8'h00);
        // Ready while idle and REQUEST without an enable both leave the FSM idle.
        mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 8'hEE;
        core_state = CORE_REQUEST;
        tick(); tick();
        chk("idle ready", lsu_state, LSU_IDLE);
        chk("idle out", lsu_out, 8'h00);
        core_state = CORE_ISSUE;
        txn(1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 0, 0);
        txn(1'b0, 1'b1, 8'h10, 8'hF3, 8'h99, 5, 0);
        txn(1'b0, 1'b1, 8'h20, 8'h11, 8'h77, 0, 4);
        txn(1'b1, 1'b0, 8'h33, 8'h00, 8'hA5, 1, 0);
        txn(1'b1, 1'b1, 8'h44, 8'h66, 8'h3C, 2, 1);
        // Enable dropped while waiting with ready high: frozen until it returns.
        start(1'b1, 1'b0, 8'h55, 8'h00);
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'hC7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pending(1'b1, 8'h55, 8'h00, "frozen");
        end
        enable = 1'b1; exp_out = 8'hC7;
        tick();
        mem_read_ready = 1'b0;
        chk("thaw state", lsu_state, LSU_DONE);
        chk("thaw out", lsu_out, 8'hC7);
        core_state = CORE_UPDATE;
        tick();
        chk("thaw idle", lsu_state, LSU_IDLE);
        core_state = CORE_ISSUE;
        // Reset while waiting abandons the load, even with enable low.
        start(1'b1, 1'b0, 8'h66, 8'h00);
        enable = 1'b0; reset = 1'b1; exp_out = 8'h00;
        tick();
        reset = 1'b0; enable = 1'b1;
        chk("mid rst state", lsu_state, LSU_IDLE);
        chk("mid rst rvalid", mem_read_valid, 1'b0);
        chk("mid rst raddr", mem_read_address, 8'h00);
        chk("mid rst out", lsu_out, 8'h00);
        mem_read_ready = 1'b1; mem_read_data = 8'hBB;
        tick();
        mem_read_ready = 1'b0;
        chk("late ready state", lsu_state, LSU_IDLE);
        chk("late ready out", lsu_out, 8'h00);
        for (int n = 0; n < 20; n++) begin
            int k;
            k = $urandom_range(1, 3);
            txn(k[0], k[1], 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 3));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
